// File: rtl/delivery_collision_checker.sv
// Lane-runner collision/delivery checker: tracks lives, score and
// invulnerability for the player cell of a scrolling obstacle map.
module delivery_collision_checker #(
  parameter int PLAYER_ROW   = 0,
  parameter int LIVES        = 3,
  parameter int INVULN_MOVES = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         move_map,
  input  logic [1:0]   player_lane,
  input  logic [511:0] map_obstacles_flat,
  input  logic [511:0] map_objectives_flat,
  output logic [7:0]   score,
  output logic [1:0]   lives,
  output logic         hit_pulse,
  output logic         collect_pulse,
  output logic         playing,
  output logic         game_over
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_HIT,
    S_OVER
  } state_t;

  state_t     state, state_n;
  logic [7:0] score_n;
  logic [1:0] lives_n, lives_dec;
  logic       hit_n, coll_n;
  logic       hit_consumed, hcons_n;
  logic       obj_consumed, ocons_n;
  logic [3:0] cnt, cnt_n;
  logic [8:0] idx;
  logic       obs, obj;
  logic       active;

  assign idx = 9'(PLAYER_ROW * 4) + {7'd0, player_lane};
  assign obs = map_obstacles_flat[idx];
  assign obj = map_objectives_flat[idx];
  assign active = (state == S_PLAY) || (state == S_HIT);
  assign lives_dec = lives - 2'd1;

  always_comb begin
    state_n = state;
    score_n = score;
    lives_n = lives;
    hit_n   = 1'b0;
    coll_n  = 1'b0;
    hcons_n = hit_consumed;
    ocons_n = obj_consumed;
    cnt_n   = cnt;
    unique case (state)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_n = S_PLAY;
          score_n = 8'd0;
          lives_n = 2'(LIVES);
          hcons_n = 1'b0;
          ocons_n = 1'b0;
          cnt_n   = 4'd0;
        end
      end
      S_PLAY: begin
        if (obs && !hit_consumed) begin
          hit_n   = 1'b1;
          lives_n = lives_dec;
          hcons_n = 1'b1;
          if (lives_dec == 2'd0) begin
            state_n = S_OVER;
          end else begin
            state_n = S_HIT;
            cnt_n   = 4'(INVULN_MOVES);
          end
        end
      end
      S_HIT: begin
        if (move_map) begin
          cnt_n = cnt - 4'd1;
          if (cnt <= 4'd1) state_n = S_PLAY;
        end
      end
      default: ;
    endcase
    if (active && obj && !obj_consumed) begin
      coll_n  = 1'b1;
      ocons_n = 1'b1;
      if (score != 8'hff) score_n = score + 8'd1;
    end
    // a map shift presents a fresh cell, so both events re-arm
    if (move_map) begin
      hcons_n = 1'b0;
      ocons_n = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      score         <= 8'd0;
      lives         <= 2'd0;
      hit_pulse     <= 1'b0;
      collect_pulse <= 1'b0;
      playing       <= 1'b0;
      game_over     <= 1'b0;
      hit_consumed  <= 1'b0;
      obj_consumed  <= 1'b0;
      cnt           <= 4'd0;
    end else begin
      state         <= state_n;
      score         <= score_n;
      lives         <= lives_n;
      hit_pulse     <= hit_n;
      collect_pulse <= coll_n;
      playing       <= (state_n == S_PLAY) || (state_n == S_HIT);
      game_over     <= (state_n == S_OVER);
      hit_consumed  <= hcons_n;
      obj_consumed  <= ocons_n;
      cnt           <= cnt_n;
    end
  end

endmodule

// File: tb/tb_delivery_collision_checker.sv
// Directed bench for delivery_collision_checker: one default instance
// and one single-life instance on row 2 sharing the same stimulus.
module tb_delivery_collision_checker;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start;
  logic         move_map;
  logic [1:0]   player_lane;
  logic [511:0] obs_map;
  logic [511:0] obj_map;

  logic [7:0] score, score1;
  logic [1:0] lives, lives1;
  logic       hit, hit1, coll, coll1;
  logic       playing, playing1, over, over1;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt;

  always #5 clock = ~clock;

  delivery_collision_checker dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .move_map(move_map), .player_lane(player_lane),
    .map_obstacles_flat(obs_map), .map_objectives_flat(obj_map),
    .score(score), .lives(lives), .hit_pulse(hit),
    .collect_pulse(coll), .playing(playing), .game_over(over)
  );

  delivery_collision_checker #(.PLAYER_ROW(2), .LIVES(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .move_map(move_map), .player_lane(player_lane),
    .map_obstacles_flat(obs_map), .map_objectives_flat(obj_map),
    .score(score1), .lives(lives1), .hit_pulse(hit1),
    .collect_pulse(coll1), .playing(playing1), .game_over(over1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    move_map = 1'b0;
    player_lane = 2'd0;
    obs_map = '0;
    obj_map = '0;
    #12;
    check("rst_score", 32'(score), 0);
    check("rst_lives", 32'(lives), 0);
    check("rst_play", 32'(playing), 0);
    check("rst_over", 32'(over), 0);
    check("rst_pulses", 32'({hit, coll, hit1, coll1}), 0);

    @(negedge clock);
    reset_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_play", 32'(playing), 1);
    check("start_lives", 32'(lives), 3);
    check("start_lives1", 32'(lives1), 1);

    // first hit
    player_lane = 2'd2;
    obs_map[2] = 1'b1;
    tick();
    check("hit_pulse", 32'(hit), 1);
    check("hit_lives", 32'(lives), 2);
    check("hit_state", 32'({playing, over}), 2);
    tick();
    check("hit_once", 32'(hit), 0);
    check("hit_lives2", 32'(lives), 2);
    obs_map[2] = 1'b0;

    // single delivery despite lane toggling
    obj_map[1] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      player_lane = (i == 1) ? 2'd0 : 2'd1;
      tick();
      cnt += 32'(coll);
    end
    check("coll_count", cnt, 1);
    check("coll_score", 32'(score), 1);
    obj_map[1] = 1'b0;

    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ign_lives", 32'(lives), 2);
    check("start_ign_score", 32'(score), 1);

    // invulnerability window
    player_lane = 2'd2;
    obs_map[2] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      move_map = 1'b1;
      tick();
      cnt += 32'(hit);
      move_map = 1'b0;
      tick();
      cnt += 32'(hit);
    end
    check("inv_no_hit", cnt, 0);
    check("inv_lives", 32'(lives), 2);
    move_map = 1'b1;
    tick();
    move_map = 1'b0;
    check("inv_end_hit", 32'(hit), 0);
    tick();
    check("rehit_pulse", 32'(hit), 1);
    check("rehit_lives", 32'(lives), 1);
    obs_map[2] = 1'b0;

    // async reset mid-HIT
    #2;
    reset_n = 1'b0;
    #1;
    check("async_hit", 32'(hit), 0);
    check("async_lives", 32'(lives), 0);
    check("async_play", 32'(playing), 0);
    check("async_score", 32'(score), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("idle_hold", 32'(playing), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_play", 32'(playing), 1);
    check("restart_lives", 32'(lives), 3);

    // score saturation
    obj_map[2] = 1'b1;
    move_map = 1'b1;
    cnt = 0;
    for (int i = 0; i < 255; i++) begin
      tick();
      cnt += 32'(coll);
    end
    check("sat_count", cnt, 255);
    check("sat_score", 32'(score), 255);
    tick();
    check("sat_pulse", 32'(coll), 1);
    check("sat_hold", 32'(score), 255);
    move_map = 1'b0;
    obj_map[2] = 1'b0;
    tick();

    // same-cell hit and delivery on the single-life instance
    obs_map[10] = 1'b1;
    obj_map[10] = 1'b1;
    tick();
    obs_map[10] = 1'b0;
    obj_map[10] = 1'b0;
    check("both_hit", 32'(hit1), 1);
    check("both_coll", 32'(coll1), 1);
    check("both_score", 32'(score1), 1);
    check("both_lives", 32'(lives1), 0);
    check("both_over", 32'({playing1, over1}), 1);
    tick();
    check("over_hold", 32'(score1), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reset_score1", 32'(score1), 0);
    check("reset_lives1", 32'(lives1), 1);
    check("reset_play1", 32'({playing1, over1}), 2);
    check("main_ign_start", 32'(score), 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
